pipeline_control: RTL
=====================

// Module: pipeline_control
// PURPOSE
// - Sequencer and hazard controller for the fetch/decode/execute/writeback pipeline.
// - Owns the PC, sequences fetch and register-file resets at startup, and issues instructions.
// - Stalls fetch and injects bubbles on RAW hazards, because the datapath has no forwarding.
// - Drains the pipeline on halt. Sits beside the datapath and drives its enables and resets.
// PARAMETERS
// - RESET_PC       32'h0  PC loaded on start/restart.
// - PC_STEP        1      PC increment per issued instruction (word-indexed imem).
// - RF_INIT_CYCLES 2      Cycles rf_reset_n/fetch_reset_n are held low in INIT (>=1).
// - DRAIN_CYCLES   3      Cycles to retire in-flight instructions after halt (>=1).
// - WB_BYPASS      0      1: regfile writes through, so a WB-stage match is not a hazard.
// - CNT_W          16     Width of the performance counters.
// PORTS
// - clock         in   1      Rising-edge clock.
// - reset_n       in   1      Asynchronous, active-low reset.
// - start         in   1      Level; IDLE/HALTED -> INIT.
// - halt_req      in   1      Level; RUN -> DRAIN.
// - rs1_de        in   5      rs1 of the instruction in decode.
// - rs2_de        in   5      rs2 of the instruction in decode.
// - use_rs1       in   1      Decode instruction reads rs1.
// - use_rs2       in   1      Decode instruction reads rs2.
// - rd_ex         in   5      Destination of the instruction in execute.
// - we_ex         in   1      Execute instruction writes rd_ex.
// - rd_wb         in   5      Destination of the instruction in writeback.
// - we_wb         in   1      Writeback instruction writes rd_wb (commit pulse).
// - pc            out  32     Registered fetch address.
// - fetch_enable  out  1      Fetch register load enable.
// - fetch_reset_n out  1      Fetch register reset, active-low.
// - rf_reset_n    out  1      Register-file reset, active-low.
// - bubble        out  1      Kill decode's write_enable_decoded this cycle.
// - stall         out  1      Hazard stall is active.
// - done          out  1      HALTED.
// - state_o       out  3      Current FSM state.
// - stall_count   out  CNT_W  Stall cycles.
// - wb_count      out  CNT_W  Committed writes.
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, pc=RESET_PC, fetch_enable=0.
//   - Reset also forces fetch_reset_n=0, rf_reset_n=0, bubble=1, stall=0, done=0.
//   - Both counters=0. On reset release, outputs follow IDLE decode.
// - FSM states and transitions:
//   - IDLE: rf_reset_n=1, fetch_reset_n=1, fetch_enable=0, bubble=1. start -> INIT.
//   - INIT: rf_reset_n=0, fetch_reset_n=0, bubble=1, pc=RESET_PC, counters cleared.
//     Leaves after exactly RF_INIT_CYCLES cycles -> RUN.
//   - RUN: resets high; fetch_enable=~stall; bubble=stall.
//     pc<=pc+PC_STEP on each non-stall cycle, else pc holds.
//     halt_req -> DRAIN, taking priority over stall; the transition cycle still obeys RUN rules.
//   - DRAIN: fetch_enable=0, bubble=1, pc holds. In-flight EX/WB instructions complete.
//     The decode-held instruction is discarded, so pc after halt = first unexecuted instruction.
//     Leaves after exactly DRAIN_CYCLES cycles -> HALTED; halt_req is ignored here.
//   - HALTED: done=1, fetch_enable=0, bubble=1. start -> INIT (restart, pc reloads).
// - Hazard, combinational, qualified only in RUN:
//   - hzd(rs) = rs!=0 && ((we_ex && rd_ex==rs) || (!WB_BYPASS && we_wb && rd_wb==rs)).
//   - stall = RUN && ((use_rs1 && hzd(rs1_de)) || (use_rs2 && hzd(rs2_de))).
//   - x0 never hazards. A simultaneous match on both sources counts as one stall cycle.
// - Stall latency: asserted in the same cycle as the match.
//   - Releases the cycle after the producer leaves WB (or leaves EX if WB_BYPASS=1).
//   - Max stall length is 2 cycles (1 if WB_BYPASS).
// - Arithmetic: pc wraps modulo 2^32, no flag.
//   - stall_count increments on every stall cycle; wb_count increments on every we_wb cycle in RUN or DRAIN.
//   - Both counters saturate at all-ones; they never wrap.
// - start and halt_req are levels; start held high in RUN/DRAIN has no effect.
// STRUCTURE
// - Package pipeline_ctrl_pkg: state enum ctrl_state_t (IDLE, INIT, RUN, DRAIN, HALTED).
//   - The package also holds the REG_ZERO=5'd0 and REG_ADDR_W=5 constants.
// - Sub-module hazard_detect: purely combinational; inputs rs/use/rd/we; outputs stall_raw.
//   - Parameterised by WB_BYPASS; reusable once forwarding is added.
// - The FSM, the shared INIT/DRAIN down-counter, the PC and the counters stay in pipeline_control.
// TESTING
// - Reset mid-RUN (pc=7):
//   - reset_n low -> pc=0, IDLE, fetch_reset_n=0, rf_reset_n=0 immediately, without waiting for a clock.
// - start=1 from IDLE, RF_INIT_CYCLES=2:
//   - rf_reset_n low for exactly 2 cycles, then RUN; pc reads 0,1,2,3 on successive cycles.
// - RAW on EX: rd_ex=3/we_ex=1, rs1_de=3/use_rs1=1:
//   - stall=1, bubble=1, fetch_enable=0, pc holds 5.
//   - Next cycle the producer is in WB: stall stays 1. It releases after, and pc->6; stall_count=2.
// - rd_ex=0/we_ex=1 with rs1_de=0: no stall.
//   - WB_BYPASS=1 with rd_wb=4 match only: no stall.
// - halt_req in RUN at pc=9:
//   - 3 DRAIN cycles with bubble=1 and pc=9 held, then done=1.
//   - wb_count counts the 2 in-flight commits.
// - Drive 2^CNT_W+5 stall cycles: stall_count saturates at 16'hFFFF.
//   - Then start from HALTED: counters cleared in INIT.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline sequencer and its hazard logic.
package pipeline_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } ctrl_state_t;
endpackage

// File: rtl/pipeline_control_if.sv
// Datapath-facing bundle: decode/execute/writeback operand info in, fetch/regfile control out.
interface pipeline_control_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] rs1_de;
  logic [REG_ADDR_W-1:0] rs2_de;
  logic                  use_rs1;
  logic                  use_rs2;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  we_ex;
  logic [REG_ADDR_W-1:0] rd_wb;
  logic                  we_wb;
  logic [31:0]           pc;
  logic                  fetch_enable;
  logic                  fetch_reset_n;
  logic                  rf_reset_n;
  logic                  bubble;
  logic                  stall;

  modport master (
    input  rs1_de, rs2_de, use_rs1, use_rs2, rd_ex, we_ex, rd_wb, we_wb,
    output pc, fetch_enable, fetch_reset_n, rf_reset_n, bubble, stall
  );

  modport slave (
    output rs1_de, rs2_de, use_rs1, use_rs2, rd_ex, we_ex, rd_wb, we_wb,
    input  pc, fetch_enable, fetch_reset_n, rf_reset_n, bubble, stall
  );
endinterface

// File: rtl/pipeline_control_hazard_detect.sv
// Combinational RAW detector for the two decode sources against the EX and WB producers.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  we_ex,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  we_wb,
  output logic                  stall_raw
);
  logic [1:0][REG_ADDR_W-1:0] src;
  logic [1:0]                 src_used;
  logic [1:0]                 src_hit;

  assign src      = {rs2, rs1};
  assign src_used = {use_rs2, use_rs1};

  // With a write-through regfile the WB producer is already visible to decode.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src[gi] != REG_ZERO) &&
                           ((we_ex && (rd_ex == src[gi])) ||
                            (!WB_BYPASS && we_wb && (rd_wb == src[gi])));
    end
  endgenerate

  assign stall_raw = |src_hit;
endmodule

// File: rtl/pipeline_control.sv
// Pipeline sequencer: owns the PC, sequences startup resets, stalls on RAW hazards and drains on halt.
module pipeline_control
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter logic [31:0] PC_STEP        = 32'd1,
  parameter int          RF_INIT_CYCLES = 2,
  parameter int          DRAIN_CYCLES   = 3,
  parameter bit          WB_BYPASS      = 1'b0,
  parameter int          CNT_W          = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               halt_req,
  pipeline_control_if.master bus,
  output logic               done,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   wb_count
);
  localparam int MAX_CYC = (RF_INIT_CYCLES > DRAIN_CYCLES) ? RF_INIT_CYCLES : DRAIN_CYCLES;
  localparam int SEQ_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [SEQ_W-1:0] INIT_LOAD  = SEQ_W'(RF_INIT_CYCLES - 1);
  localparam logic [SEQ_W-1:0] DRAIN_LOAD = SEQ_W'(DRAIN_CYCLES - 1);

  ctrl_state_t      state_reg, state_next;
  logic [SEQ_W-1:0] seq_reg, seq_next;
  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] wb_cnt_reg, wb_cnt_next;
  logic             stall_raw;
  logic             stall;
  logic             in_run;

  hazard_detect #(.WB_BYPASS(WB_BYPASS)) u_hazard (
    .rs1       (bus.rs1_de),
    .rs2       (bus.rs2_de),
    .use_rs1   (bus.use_rs1),
    .use_rs2   (bus.use_rs2),
    .rd_ex     (bus.rd_ex),
    .we_ex     (bus.we_ex),
    .rd_wb     (bus.rd_wb),
    .we_wb     (bus.we_wb),
    .stall_raw (stall_raw)
  );

  assign in_run = (state_reg == RUN);
  assign stall  = in_run && stall_raw;

  always_comb begin
    state_next     = state_reg;
    seq_next       = seq_reg;
    pc_next        = pc_reg;
    stall_cnt_next = stall_cnt_reg;
    wb_cnt_next    = wb_cnt_reg;

    if (stall && (stall_cnt_reg != '1)) stall_cnt_next = stall_cnt_reg + 1'b1;
    if (bus.we_wb && (in_run || state_reg == DRAIN) && (wb_cnt_reg != '1))
      wb_cnt_next = wb_cnt_reg + 1'b1;

    // One down-counter times both INIT and DRAIN; it is reloaded on entry to each.
    case (state_reg)
      IDLE, HALTED: begin
        if (start) begin
          state_next     = INIT;
          seq_next       = INIT_LOAD;
          pc_next        = RESET_PC;
          stall_cnt_next = '0;
          wb_cnt_next    = '0;
        end
      end
      INIT: begin
        pc_next        = RESET_PC;
        stall_cnt_next = '0;
        wb_cnt_next    = '0;
        if (seq_reg == '0) state_next = RUN;
        else               seq_next   = seq_reg - 1'b1;
      end
      RUN: begin
        if (!stall) pc_next = pc_reg + PC_STEP;
        if (halt_req) begin
          state_next = DRAIN;
          seq_next   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (seq_reg == '0) state_next = HALTED;
        else               seq_next   = seq_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      seq_reg       <= '0;
      pc_reg        <= RESET_PC;
      stall_cnt_reg <= '0;
      wb_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      seq_reg       <= seq_next;
      pc_reg        <= pc_next;
      stall_cnt_reg <= stall_cnt_next;
      wb_cnt_reg    <= wb_cnt_next;
    end
  end

  // Datapath resets follow reset_n directly so they drop without waiting for a clock.
  assign bus.fetch_reset_n = reset_n && (state_reg != INIT);
  assign bus.rf_reset_n    = reset_n && (state_reg != INIT);
  assign bus.pc            = pc_reg;
  assign bus.stall         = stall;
  assign bus.fetch_enable  = in_run && !stall;
  assign bus.bubble        = !in_run || stall;
  assign done              = (state_reg == HALTED);
  assign state_o           = state_reg;
  assign stall_count       = stall_cnt_reg;
  assign wb_count          = wb_cnt_reg;
endmodule
